// File: rtl/cmos_gray_crop_pack_pkg.sv
`default_nettype none
// =============================================================================
// cmos_gray_crop_pack_pkg: shared widths and FSM encoding for the crop/pack block. Rev 1.0
// =============================================================================
package cmos_gray_crop_pack_pkg;

  localparam int PIX_W  = 8;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 12;
  localparam int WCNT_W = 24;

  typedef enum logic {
    WAIT_VS = 1'b0,
    ACTIVE  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/cmos_gray_crop_pack_sync_edge.sv
`default_nettype none
// =============================================================================
// cmos_gray_crop_pack_sync_edge: one-stage vsync/href history with edge pulses. Rev 1.0
// =============================================================================
module cmos_gray_crop_pack_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  input  logic href,
  output logic vs_rise,
  output logic vs_fall,
  output logic hs_fall
);

  logic vs_q, vs_d;
  logic hs_q, hs_d;

  always_comb begin
    vs_d = vsync;
    hs_d = href;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      hs_q <= 1'b0;
    end else begin
      vs_q <= vs_d;
      hs_q <= hs_d;
    end
  end

  assign vs_rise = vsync & ~vs_q;
  assign vs_fall = ~vsync & vs_q;
  assign hs_fall = ~href & hs_q;

endmodule
`default_nettype wire

// File: rtl/cmos_gray_crop_pack.sv
`default_nettype none
// =============================================================================
// cmos_gray_crop_pack: crops a window of the 8-bit pixel stream, packs pixel pairs. Rev 1.0
// =============================================================================
module cmos_gray_crop_pack
  import cmos_gray_crop_pack_pkg::*;
#(
  parameter logic [CNT_W-1:0] H_START  = 12'd0,
  parameter logic [CNT_W-1:0] V_START  = 12'd0,
  parameter logic [CNT_W-1:0] H_WIDTH  = 12'd640,
  parameter logic [CNT_W-1:0] V_HEIGHT = 12'd480
) (
  input  logic              cmos_pclk,
  input  logic              rst_n,
  input  logic              per_frame_vsync,
  input  logic              per_frame_href,
  input  logic              per_frame_clken,
  input  logic [PIX_W-1:0]  per_img_data,
  output logic              wr_en,
  output logic [WORD_W-1:0] wr_data,
  output logic              wr_frame_start,
  output logic              wr_frame_done,
  output logic              frame_err,
  output logic [CNT_W-1:0]  frame_width,
  output logic [CNT_W-1:0]  frame_height
);

  localparam logic [CNT_W:0]    H_END       = {1'b0, H_START} + {1'b0, H_WIDTH};
  localparam logic [CNT_W:0]    V_END       = {1'b0, V_START} + {1'b0, V_HEIGHT};
  localparam logic [WCNT_W-1:0] FRAME_WORDS = WCNT_W'((32'(H_WIDTH) * 32'(V_HEIGHT)) >> 1);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [WCNT_W-1:0] WCNT_ONE    = WCNT_W'(1);

  logic vs_rise, vs_fall, hs_fall;

  cmos_gray_crop_pack_sync_edge u_sync_edge (
    .clk     (cmos_pclk),
    .rst_n   (rst_n),
    .vsync   (per_frame_vsync),
    .href    (per_frame_href),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall),
    .hs_fall (hs_fall)
  );

  state_e              state_q, state_d;
  logic                armed_q, armed_d;
  logic [CNT_W-1:0]    x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic                phase_q, phase_d;
  logic [PIX_W-1:0]    hold_q, hold_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic                sticky_q, sticky_d;
  logic [CNT_W-1:0]    width_lat_q, width_lat_d;
  logic                done_pend_q, done_pend_d;
  logic                wr_en_q, wr_en_d;
  logic [WORD_W-1:0]   wr_data_q, wr_data_d;
  logic                start_q, start_d, done_q, done_d, err_q, err_d;
  logic [CNT_W-1:0]    fw_q, fw_d, fh_q, fh_d;

  logic in_win, pix_ok, line_end, finish, word_inc;

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q | ~per_frame_vsync;
    x_cnt_d     = x_cnt_q;
    y_cnt_d     = y_cnt_q;
    phase_d     = phase_q;
    hold_d      = hold_q;
    word_cnt_d  = word_cnt_q;
    sticky_d    = sticky_q;
    width_lat_d = width_lat_q;
    done_pend_d = 1'b0;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    start_d     = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    fw_d        = fw_q;
    fh_d        = fh_q;
    finish      = 1'b0;
    word_inc    = 1'b0;

    in_win   = (x_cnt_q >= H_START) && ({1'b0, x_cnt_q} < H_END) &&
               (y_cnt_q >= V_START) && ({1'b0, y_cnt_q} < V_END);
    pix_ok   = (state_q == ACTIVE) && per_frame_vsync && per_frame_href && per_frame_clken;
    // A vsync drop with href still high closes the line just like an href fall.
    line_end = (state_q == ACTIVE) && (hs_fall || (vs_fall && per_frame_href));

    case (state_q)
      WAIT_VS: begin
        // armed_q keeps a frame already in progress at reset release from being accepted.
        if (vs_rise && armed_q) begin
          state_d    = ACTIVE;
          start_d    = 1'b1;
          x_cnt_d    = '0;
          y_cnt_d    = '0;
          phase_d    = 1'b0;
          word_cnt_d = '0;
          sticky_d   = 1'b0;
        end
      end
      ACTIVE: begin
        if (vs_fall) begin
          state_d     = WAIT_VS;
          done_pend_d = line_end;
          finish      = ~line_end;
        end
      end
    endcase

    if (pix_ok) begin
      if (x_cnt_q != '1) x_cnt_d = x_cnt_q + CNT_ONE;
      if (in_win) begin
        if (!phase_q) begin
          hold_d  = per_img_data;
          phase_d = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_data_d = {hold_q, per_img_data};
          phase_d   = 1'b0;
          word_inc  = 1'b1;
        end
      end
    end

    if (line_end) begin
      x_cnt_d = '0;
      phase_d = 1'b0;
      if (y_cnt_q != '1) y_cnt_d = y_cnt_q + CNT_ONE;
      if (x_cnt_q != '0) width_lat_d = x_cnt_q;
      if (phase_q) begin
        wr_en_d   = 1'b1;
        wr_data_d = {hold_q, {PIX_W{1'b0}}};
        sticky_d  = 1'b1;
        word_inc  = 1'b1;
      end
    end

    if (word_inc && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + WCNT_ONE;

    // A delayed done samples the registers after the closing line has been folded in.
    if (finish || done_pend_q) begin
      done_d = 1'b1;
      err_d  = sticky_q | (word_cnt_q != FRAME_WORDS);
      fw_d   = width_lat_q;
      fh_d   = y_cnt_q;
    end
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_VS;
      armed_q     <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      phase_q     <= 1'b0;
      hold_q      <= '0;
      word_cnt_q  <= '0;
      sticky_q    <= 1'b0;
      width_lat_q <= '0;
      done_pend_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      fw_q        <= '0;
      fh_q        <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      word_cnt_q  <= word_cnt_d;
      sticky_q    <= sticky_d;
      width_lat_q <= width_lat_d;
      done_pend_q <= done_pend_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      fw_q        <= fw_d;
      fh_q        <= fh_d;
    end
  end

  assign wr_en          = wr_en_q;
  assign wr_data        = wr_data_q;
  assign wr_frame_start = start_q;
  assign wr_frame_done  = done_q;
  assign frame_err      = err_q;
  assign frame_width    = fw_q;
  assign frame_height   = fh_q;

endmodule
`default_nettype wire

// File: tb/tb_cmos_gray_crop_pack.sv
`default_nettype none
// =============================================================================
// tb_cmos_gray_crop_pack: two window configurations driven by one stream, model-checked. Rev 1.0
// =============================================================================
module tb_cmos_gray_crop_pack;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vs = 1'b0, hs = 1'b0, ce = 1'b0;
  logic [7:0] din = 8'h00;

  logic        wr_en_o [2];
  logic [15:0] wr_data_o [2];
  logic        start_o [2];
  logic        done_o [2];
  logic        err_o [2];
  logic [11:0] fw_o [2];
  logic [11:0] fh_o [2];

  always #5 clk = ~clk;

  cmos_gray_crop_pack #(
    .H_START(12'd2), .V_START(12'd1), .H_WIDTH(12'd4), .V_HEIGHT(12'd2)
  ) dut_a (
    .cmos_pclk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hs),
    .per_frame_clken(ce), .per_img_data(din), .wr_en(wr_en_o[0]), .wr_data(wr_data_o[0]),
    .wr_frame_start(start_o[0]), .wr_frame_done(done_o[0]), .frame_err(err_o[0]),
    .frame_width(fw_o[0]), .frame_height(fh_o[0])
  );

  cmos_gray_crop_pack #(
    .H_START(12'd5), .V_START(12'd1), .H_WIDTH(12'd4), .V_HEIGHT(12'd1)
  ) dut_b (
    .cmos_pclk(clk), .rst_n(rst_n), .per_frame_vsync(vs), .per_frame_href(hs),
    .per_frame_clken(ce), .per_img_data(din), .wr_en(wr_en_o[1]), .wr_data(wr_data_o[1]),
    .wr_frame_start(start_o[1]), .wr_frame_done(done_o[1]), .frame_err(err_o[1]),
    .frame_width(fw_o[1]), .frame_height(fh_o[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int epoch = 0;

  // Observed events, owned by the monitor process only.
  logic [47:0] obs_w [2][64];
  int          n_w [2];
  int          n_start [2], start_cyc [2];
  int          n_done [2], done_cyc [2];
  logic        done_err [2];
  logic [11:0] done_w [2], done_h [2];
  int          overlap [2];
  int          seen_epoch = 0;

  // Stimulus record of the current frame.
  logic [7:0] pix [16][16];
  int         pcyc [16][16];
  int         llen [16];
  int         lend_cyc [16];
  int         nlines, vsr_cyc, vsf_cyc;
  bit         merged;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (epoch != seen_epoch) begin
      seen_epoch = epoch;
      for (int d = 0; d < 2; d++) begin
        n_w[d] = 0; n_start[d] = 0; n_done[d] = 0; overlap[d] = 0;
        start_cyc[d] = -1; done_cyc[d] = -1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (wr_en_o[d]) begin
        if (n_w[d] < 64) obs_w[d][n_w[d]] = {32'(cyc), wr_data_o[d]};
        n_w[d]++;
      end
      if (start_o[d]) begin
        n_start[d]++;
        start_cyc[d] = cyc;
      end
      if (done_o[d]) begin
        n_done[d]++;
        done_cyc[d] = cyc;
        done_err[d] = err_o[d];
        done_w[d]   = fw_o[d];
        done_h[d]   = fh_o[d];
      end
      if (wr_en_o[d] && (start_o[d] || done_o[d])) overlap[d]++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_epoch();
    epoch++;
    tick();
  endtask

  // mode 0: continuous clken, 1: alternating, 2: random gaps
  task automatic run_frame(input int w, input int h, input int mode, input bit merge,
                           input bit pattern);
    bit alt;
    bit ce_t;
    alt = 1'b0;
    nlines = h;
    merged = merge;
    vs = 1'b1;
    vsr_cyc = cyc;
    repeat (3) tick();
    for (int y = 0; y < h; y++) begin
      int col;
      col = 0;
      hs = 1'b1;
      while (col < w) begin
        alt = ~alt;
        case (mode)
          0:       ce_t = 1'b1;
          1:       ce_t = alt;
          default: ce_t = ($urandom_range(0, 2) != 0);
        endcase
        ce  = ce_t;
        din = 8'($urandom);
        if (ce_t) begin
          if (pattern) din = 8'(16 * y + col);
          pix[y][col]  = din;
          pcyc[y][col] = cyc;
          col++;
        end
        tick();
      end
      ce = 1'b0;
      llen[y] = w;
      hs = 1'b0;
      lend_cyc[y] = cyc;
      if (merge && (y == h - 1)) begin
        vs = 1'b0;
        vsf_cyc = cyc;
        tick();
      end else begin
        repeat (3) tick();
      end
    end
    if (!merge) begin
      vs = 1'b0;
      vsf_cyc = cyc;
      tick();
    end
    repeat (5) tick();
  endtask

  // Reference: crop each line to the window, pair the survivors, pad an odd leftover.
  task automatic check_frame(input int d, input int hst, input int vst, input int hw, input int vh);
    logic [47:0] exp_w [64];
    int n;
    bit err;
    int sel [$];
    n = 0;
    err = 1'b0;
    for (int y = 0; y < nlines; y++) begin
      if (y >= vst && y < vst + vh) begin
        sel.delete();
        for (int c = 0; c < llen[y]; c++)
          if (c >= hst && c < hst + hw) sel.push_back(c);
        for (int k = 0; k + 1 < sel.size(); k += 2) begin
          exp_w[n] = {32'(pcyc[y][sel[k+1]] + 1), pix[y][sel[k]], pix[y][sel[k+1]]};
          n++;
        end
        if (sel.size() % 2 == 1) begin
          exp_w[n] = {32'(lend_cyc[y] + 1), pix[y][sel[sel.size()-1]], 8'h00};
          n++;
          err = 1'b1;
        end
      end
    end
    if (n != hw * vh / 2) err = 1'b1;
    check_val($sformatf("d%0d_start_count", d), 64'(n_start[d]), 64'd1);
    check_val($sformatf("d%0d_start_cycle", d), 64'(start_cyc[d]), 64'(vsr_cyc + 1));
    check_val($sformatf("d%0d_word_count", d), 64'(n_w[d]), 64'(n));
    for (int k = 0; k < n && k < n_w[d]; k++)
      check_val($sformatf("d%0d_word%0d_cyc_data", d, k), 64'(obs_w[d][k]), 64'(exp_w[k]));
    check_val($sformatf("d%0d_done_count", d), 64'(n_done[d]), 64'd1);
    check_val($sformatf("d%0d_done_cycle", d), 64'(done_cyc[d]), 64'(vsf_cyc + 1 + int'(merged)));
    check_val($sformatf("d%0d_frame_err", d), 64'(done_err[d]), 64'(err));
    check_val($sformatf("d%0d_frame_width", d), 64'(done_w[d]), 64'(llen[nlines-1]));
    check_val($sformatf("d%0d_frame_height", d), 64'(done_h[d]), 64'(nlines));
    check_val($sformatf("d%0d_wr_overlap", d), 64'(overlap[d]), 64'd0);
  endtask

  task automatic check_both();
    check_frame(0, 2, 1, 4, 2);
    check_frame(1, 5, 1, 4, 1);
  endtask

  initial begin
    logic [15:0] wv;
    repeat (3) tick();
    for (int d = 0; d < 2; d++)
      check_val($sformatf("d%0d_reset_outputs", d),
                64'({wr_en_o[d], wr_data_o[d], start_o[d], done_o[d], err_o[d], fw_o[d], fh_o[d]}),
                64'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // 8x4 frame, continuous clken, pixel = 16*line + col
    new_epoch();
    run_frame(8, 4, 0, 1'b0, 1'b1);
    check_both();
    wv = obs_w[0][0][15:0];
    check_val("s1_first_word", 64'(wv), 64'h1213);
    wv = obs_w[0][3][15:0];
    check_val("s1_last_word", 64'(wv), 64'h2425);
    wv = obs_w[1][1][15:0];
    check_val("s5_pad_word", 64'(wv), 64'h1700);

    // Same frame with alternating clken
    new_epoch();
    run_frame(8, 4, 1, 1'b0, 1'b1);
    check_both();

    // Reset released while vsync is high: that frame must be ignored entirely
    new_epoch();
    rst_n = 1'b0;
    vs = 1'b1;
    tick();
    hs = 1'b1;
    ce = 1'b1;
    repeat (3) begin din = 8'($urandom); tick(); end
    rst_n = 1'b1;
    repeat (5) begin din = 8'($urandom); tick(); end
    ce = 1'b0; hs = 1'b0;
    repeat (2) tick();
    hs = 1'b1; ce = 1'b1;
    repeat (8) begin din = 8'($urandom); tick(); end
    ce = 1'b0; hs = 1'b0;
    tick();
    vs = 1'b0;
    repeat (6) tick();
    for (int d = 0; d < 2; d++) begin
      check_val($sformatf("d%0d_dropped_words", d), 64'(n_w[d]), 64'd0);
      check_val($sformatf("d%0d_dropped_starts", d), 64'(n_start[d]), 64'd0);
      check_val($sformatf("d%0d_dropped_dones", d), 64'(n_done[d]), 64'd0);
    end
    new_epoch();
    run_frame(8, 4, 0, 1'b0, 1'b1);
    check_both();

    // Too-short frame
    new_epoch();
    run_frame(8, 2, 0, 1'b0, 1'b1);
    check_both();

    // href and vsync fall together on the last line
    new_epoch();
    run_frame(8, 2, 0, 1'b1, 1'b1);
    check_both();
    new_epoch();
    run_frame(7, 2, 2, 1'b1, 1'b1);
    check_both();

    // Randomized frames
    for (int f = 0; f < 25; f++) begin
      new_epoch();
      run_frame($urandom_range(2, 12), $urandom_range(1, 5), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), 1'b0);
      check_both();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
